stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
Controller that shares one hardware stack (push/pop datapath with 32-bit write word, 8-bit combinational read word) between two requesters: the call/return unit (r0) and the data push/pop unit (r1). It arbitrates round-robin, sequences exactly one PUSH or POP pulse per accepted request, and captures the pop result. It tracks stack depth and rejects overflow and underflow before they reach the stack.

Parameters:
DEPTH, 2048, stack capacity in words; full when depth == DEPTH
DATA_W, 32, push data width
OUT_W, 8, pop data width
CNT_W, 12, depth counter width; must hold DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
r0_valid  in  1  requester 0 request
r0_op  in  1  0 = push, 1 = pop
r0_wdata  in  DATA_W  push data
r0_ready  out  1  request accepted this cycle
r0_rvalid  out  1  one-cycle completion pulse
r1_valid/r1_op/r1_wdata/r1_ready/r1_rvalid  same as r0, for requester 1
rdata  out  OUT_W  pop data, valid with rN_rvalid
err  out  1  completion was rejected (overflow/underflow), valid with rN_rvalid
stk_push  out  1  to stack PUSH
stk_pop  out  1  to stack POP
stk_wdata  out  DATA_W  to stack Input
stk_rdata  in  OUT_W  from stack OUTPUT, combinational while stk_pop = 1
depth  out  CNT_W  current occupancy
full  out  1  depth == DEPTH
empty  out  1  depth == 0

Behaviour:
- States: IDLE, ISSUE, DONE. Fixed 3-cycle transaction: accept, issue, complete.
- IDLE: if any rN_valid, assert rN_ready combinationally for the winner only. Latch the owner, op and wdata, then go to ISSUE. With no valid request, stay in IDLE.
- Arbitration: single-valid wins. When both are valid, the requester not granted last wins. last_grant resets to 1, so r0 wins the first contest.
- ISSUE, legal op:
  - push, not full: stk_push = 1 for exactly this cycle; stk_wdata = latched data; depth + 1 at the clock edge.
  - pop, not empty: stk_pop = 1 for exactly this cycle; register stk_rdata into rdata; depth − 1 at the clock edge.
- ISSUE, illegal op (push when full, pop when empty): no stk_push or stk_pop; set err register; depth unchanged. Go to DONE.
- DONE: owner's rN_rvalid = 1 for one cycle, with rdata and err valid. Update last_grant = owner and return to IDLE.
- rdata holds its last pop value and is unchanged by push completions. err clears when the next request is accepted.
- stk_push and stk_pop are never both 1. At most one rN_ready and at most one rN_rvalid is high per cycle.
- stk_wdata = 0 outside ISSUE.
- full and empty are decoded from the registered depth.
- Requests presented outside IDLE see ready = 0 and must hold valid.
- Reset (rst = 0, at any time including mid-ISSUE): state = IDLE, depth = 0, last_grant = 1, rdata = 0, err = 0.
  - All outputs 0 except empty = 1.
  - stk_push and stk_pop drop immediately because they are decoded from the reset state.
- The stack's own pointer is reset by the same rst, which keeps depth consistent with it.

Optional Feature:
STACK_ARB_STICKY_ERR_EN
- Defined: adds input err_clr (1 bit) and output err_status (2 bits).
  - bit0 sets on a rejected push (overflow); bit1 sets on a rejected pop (underflow).
  - Both bits are sticky until err_clr = 1 clears them at the clock edge. A set on the same cycle as err_clr wins.
  - Reset value 0.
- Undefined: neither port exists; only the per-transaction err is reported.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, then release → depth = 0, empty = 1, full = 0, all handshake and stack outputs 0.
- r0 push 0xDEADBEEF at cycle T → r0_ready at T, stk_push = 1 with stk_wdata = 0xDEADBEEF at T+1, r0_rvalid = 1 with err = 0 at T+2, depth = 1.
- r1 pop with model stk_rdata = 0xEF during stk_pop → stk_pop at T+1, r1_rvalid at T+2 with rdata = 0xEF, depth = 0, empty = 1.
- r0 and r1 both continuously request push (DEPTH = 8) → grants alternate r0, r1, r0, r1… with r0 first; a new grant every 3 cycles; depth increments by 1 each.
- DEPTH = 4: five pushes → 5th completes with err = 1 and no stk_push, depth stays 4. Then 5 pops → 5th has err = 1 and no stk_pop. With the macro defined, err_status = 2'b11 until err_clr.
- Assert rst = 0 during ISSUE of a push → stk_push falls within the same cycle, and after release state = IDLE, depth = 0, and no rvalid is ever emitted for the aborted request.

Source files
------------

// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//
// Lets two requesters share one hardware stack. Requester 0 is the call/return
// unit and requester 1 is the data push/pop unit. Requests are granted
// round-robin. Each accepted request takes exactly three cycles:
//   IDLE  : accept. rN_ready is high for the winner only.
//   ISSUE : at most one stk_push or stk_pop pulse. A pop captures stk_rdata.
//   DONE  : a one-cycle rN_rvalid to the owner, with rdata and err valid.
// Overflow (push when full) and underflow (pop when empty) are caught in ISSUE.
// They never reach the stack. They are reported through err.
//
// Optional feature macro: STACK_ARB_STICKY_ERR_EN
//   When defined, this adds input err_clr and output err_status[1:0].
//   bit0 is a sticky overflow flag and bit1 is a sticky underflow flag.
//   err_clr clears both bits, but a new set in the same cycle wins.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active low
//   rN_valid/op/wdata   request (op 0 = push, 1 = pop), held until ready
//   rN_ready            request accepted this cycle
//   rN_rvalid           completion pulse
//   rdata               last pop value, valid with rN_rvalid
//   err                 completion was rejected, valid with rN_rvalid
//   stk_push/stk_pop    stack command pulses
//   stk_wdata           push word, zero outside ISSUE
//   stk_rdata           stack output, combinational while stk_pop = 1
//   depth/full/empty    occupancy, tracked here in step with the stack
// -----------------------------------------------------------------------------
module stack_arbiter #(
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r0_op,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic              r0_rvalid,
    input  logic              r1_valid,
    input  logic              r1_op,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [OUT_W-1:0]  rdata,
    output logic              err,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [OUT_W-1:0]  stk_rdata,
`ifdef STACK_ARB_STICKY_ERR_EN
    input  logic              err_clr,
    output logic [1:0]        err_status,
`endif
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic               last_grant_reg;   // 0 = r0, 1 = r1
    logic               owner_reg;
    logic               op_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [CNT_W-1:0]   depth_reg;
    logic [OUT_W-1:0]   rdata_reg;
    logic               err_reg;

    logic               accept;
    logic               grant_owner;      // 0 = r0 wins, 1 = r1 wins
    logic               issue_push;
    logic               issue_pop;
    logic               issue_reject;

    // Occupancy flags come from the registered depth.
    assign full  = (depth_reg == CNT_W'(DEPTH));
    assign empty = (depth_reg == '0);
    assign depth = depth_reg;
    assign rdata = rdata_reg;
    assign err   = err_reg;

    // Round-robin: a lone request wins. When both requesters are valid, the
    // one not granted last time wins. last_grant resets to 1, so r0 wins the
    // first contest.
    assign grant_owner = r1_valid & (~r0_valid | ~last_grant_reg);

    // rst is folded in so that no ready is seen while reset is held.
    assign accept = (state_reg == IDLE) & (r0_valid | r1_valid) & rst;

    assign issue_push   = (state_reg == ISSUE) & ~op_reg & ~full;
    assign issue_pop    = (state_reg == ISSUE) &  op_reg & ~empty;
    assign issue_reject = (state_reg == ISSUE) & ~issue_push & ~issue_pop;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------- next-state comb
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- output comb
    // The stack commands are decoded from state, so a reset during ISSUE drops
    // them at once.
    always_comb begin
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_wdata = '0;
        case (state_reg)
            IDLE: begin
                r0_ready = accept & ~grant_owner;
                r1_ready = accept &  grant_owner;
            end
            ISSUE: begin
                stk_push  = issue_push;
                stk_pop   = issue_pop;
                stk_wdata = wdata_reg;
            end
            DONE: begin
                r0_rvalid = ~owner_reg;
                r1_rvalid =  owner_reg;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            op_reg         <= 1'b0;
            wdata_reg      <= '0;
            depth_reg      <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (accept) begin
                owner_reg <= grant_owner;
                op_reg    <= grant_owner ? r1_op    : r0_op;
                wdata_reg <= grant_owner ? r1_wdata : r0_wdata;
                err_reg   <= 1'b0;
            end
            if (issue_push) begin
                depth_reg <= depth_reg + 1'b1;
            end
            if (issue_pop) begin
                depth_reg <= depth_reg - 1'b1;
                rdata_reg <= stk_rdata;
            end
            if (issue_reject) begin
                err_reg <= 1'b1;
            end
            if (state_reg == DONE) begin
                last_grant_reg <= owner_reg;
            end
        end
    end

`ifdef STACK_ARB_STICKY_ERR_EN
    // Sticky error flags. Each bit is cleared first, then any new set is
    // applied, so a set in the same cycle as err_clr wins.
    logic [1:0] err_status_reg;
    logic [1:0] err_set;

    assign err_set    = {issue_reject & op_reg, issue_reject & ~op_reg};
    assign err_status = err_status_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_status_reg <= 2'b00;
        end else begin
            err_status_reg <= (err_clr ? 2'b00 : err_status_reg) | err_set;
        end
    end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 12;

    logic              clk;
    logic              rst;
    logic              r0_valid, r0_op, r0_ready, r0_rvalid;
    logic              r1_valid, r1_op, r1_ready, r1_rvalid;
    logic [DATA_W-1:0] r0_wdata, r1_wdata;
    logic [OUT_W-1:0]  rdata;
    logic              err;
    logic              stk_push, stk_pop;
    logic [DATA_W-1:0] stk_wdata;
    logic [OUT_W-1:0]  stk_rdata;
    logic [CNT_W-1:0]  depth;
    logic              full, empty;
`ifdef STACK_ARB_STICKY_ERR_EN
    logic              err_clr;
    logic [1:0]        err_status;
`endif

    int total = 0;
    int bad   = 0;

    stack_arbiter #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r0_op     (r0_op),
        .r0_wdata  (r0_wdata),
        .r0_ready  (r0_ready),
        .r0_rvalid (r0_rvalid),
        .r1_valid  (r1_valid),
        .r1_op     (r1_op),
        .r1_wdata  (r1_wdata),
        .r1_ready  (r1_ready),
        .r1_rvalid (r1_rvalid),
        .rdata     (rdata),
        .err       (err),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .stk_rdata (stk_rdata),
`ifdef STACK_ARB_STICKY_ERR_EN
        .err_clr   (err_clr),
        .err_status(err_status),
`endif
        .depth     (depth),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack. Its read port is combinational while stk_pop is high.
    logic [DATA_W-1:0] mem [0:7];
    int                sp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= 0;
        end else if (stk_push && sp < 8) begin
            mem[sp] <= stk_wdata;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    always_comb begin
        stk_rdata = '0;
        if (stk_pop && sp > 0) stk_rdata = mem[sp-1][OUT_W-1:0];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from a single requester.
    //   exp_stk : the command is legal, so a stack pulse is expected.
    task automatic do_txn(input int who, input logic op, input logic [31:0] wd,
                          input logic exp_stk, input logic exp_err,
                          input logic [7:0] exp_rdata, input int exp_depth);
        r0_valid = (who == 0); r0_op = op; r0_wdata = wd;
        r1_valid = (who == 1); r1_op = op; r1_wdata = wd;
        #1;
        check("ready_owner", 64'(who == 0 ? r0_ready : r1_ready), 64'(1));
        check("ready_other", 64'(who == 0 ? r1_ready : r0_ready), 64'(0));
        step();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        check("issue_push", 64'(stk_push), 64'(exp_stk & ~op));
        check("issue_pop",  64'(stk_pop),  64'(exp_stk &  op));
        if (!op) check("issue_wdata", 64'(stk_wdata), 64'(wd));
        step();
        check("rvalid_owner", 64'(who == 0 ? r0_rvalid : r1_rvalid), 64'(1));
        check("rvalid_other", 64'(who == 0 ? r1_rvalid : r0_rvalid), 64'(0));
        check("done_err",   64'(err),   64'(exp_err));
        check("done_rdata", 64'(rdata), 64'(exp_rdata));
        check("done_depth", 64'(depth), 64'(exp_depth));
        $display("txn r%0d op=%s wd=%08h err=%0b rdata=%02h depth=%0d",
                 who, op ? "pop " : "push", wd, err, rdata, depth);
        step();
        check("idle_wdata", 64'(stk_wdata), 64'(0));
    endtask

    initial begin
        rst = 1'b0;
        r0_valid = 1'b0; r0_op = 1'b0; r0_wdata = '0;
        r1_valid = 1'b0; r1_op = 1'b0; r1_wdata = '0;
`ifdef STACK_ARB_STICKY_ERR_EN
        err_clr = 1'b0;
`endif
        // Reset held for 3 cycles. A request during reset must not be granted.
        step(); step();
        r0_valid = 1'b1;
        step();
        check("rst_ready0", 64'(r0_ready), 64'(0));
        r0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_depth", 64'(depth), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full",  64'(full),  64'(0));
        check("rst_hs", 64'({r0_ready, r1_ready, r0_rvalid, r1_rvalid}), 64'(0));
        check("rst_stk", 64'({stk_push, stk_pop}), 64'(0));
        check("rst_wdata", 64'(stk_wdata), 64'(0));
        check("rst_rdata_err", 64'({rdata, err}), 64'(0));
        step();

        // r0 pushes DEADBEEF. r1 then pops it and gets the low byte EF.
        do_txn(0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1);
        do_txn(1, 1'b1, 32'h0,        1'b1, 1'b0, 8'hEF, 0);
        check("pop_empty", 64'(empty), 64'(1));

        // Both requesters push continuously. Grants alternate, starting with r0.
        r0_valid = 1'b1; r0_op = 1'b0; r0_wdata = 32'hA0A00011;
        r1_valid = 1'b1; r1_op = 1'b0; r1_wdata = 32'hB0B00022;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", 64'(r0_ready), 64'(i % 2 == 0));
            check("rr_ready1", 64'(r1_ready), 64'(i % 2 == 1));
            step();
            check("rr_issue_ready", 64'({r0_ready, r1_ready}), 64'(0));
            check("rr_push", 64'(stk_push), 64'(1));
            step();
            check("rr_rvalid", 64'({r1_rvalid, r0_rvalid}), 64'(i % 2 == 0 ? 1 : 2));
            check("rr_depth", 64'(depth), 64'(i + 1));
            $display("txn contest grant=r%0d depth=%0d", i % 2, depth);
            step();
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        check("full_flag", 64'(full), 64'(1));

        // A fifth push overflows. rdata keeps EF from the earlier pop.
        do_txn(0, 1'b0, 32'h12345678, 1'b0, 1'b1, 8'hEF, 4);
`ifdef STACK_ARB_STICKY_ERR_EN
        check("sticky_ovf", 64'(err_status), 64'(2'b01));
`endif
        do_txn(1, 1'b1, 32'h0, 1'b1, 1'b0, 8'h22, 3);
        do_txn(1, 1'b1, 32'h0, 1'b1, 1'b0, 8'h11, 2);
        do_txn(0, 1'b1, 32'h0, 1'b1, 1'b0, 8'h22, 1);
        do_txn(1, 1'b1, 32'h0, 1'b1, 1'b0, 8'h11, 0);
        // A fifth pop underflows.
        do_txn(1, 1'b1, 32'h0, 1'b0, 1'b1, 8'h11, 0);
`ifdef STACK_ARB_STICKY_ERR_EN
        check("sticky_both", 64'(err_status), 64'(2'b11));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("sticky_clr", 64'(err_status), 64'(2'b00));
`endif

        // Reset arrives during ISSUE of a push.
        r0_valid = 1'b1; r0_op = 1'b0; r0_wdata = 32'h55;
        step();
        r0_valid = 1'b0;
        check("abort_push_pre", 64'(stk_push), 64'(1));
        rst = 1'b0;
        #1;
        check("abort_push_drop", 64'(stk_push), 64'(0));
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("abort_rvalid", 64'({r0_rvalid, r1_rvalid}), 64'(0));
            check("abort_depth", 64'(depth), 64'(0));
            step();
        end
        check("abort_empty", 64'(empty), 64'(1));
        $display("txn reset-abort depth=%0d", depth);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
